// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Groups the signals between the IF-stage fetch controller and its neighbours:
// the PC register, the redirect/flush source, instruction memory and IF/ID.
//
// Signals:
//   pc              PC register value feeding the fetch controller
//   pc_write        PC register update enable
//   flush           redirect/kill; the PC mux carries the target this cycle
//   imem_req_*      fetch request (valid/ready/address)
//   imem_resp_*     single-cycle response pulse with the fetched word
//   id_valid/ready  IF/ID handshake
//   id_pc/id_instr  contents of IF/ID
//   id_fault        misaligned-fetch marker (only with FETCH_MISALIGN_CHK_EN)
//
// Modports:
//   master  the fetch controller's view
//   slave   the surrounding pipeline/memory view
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN adds id_fault.
// -----------------------------------------------------------------------------
interface if_fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  pc;
  logic               pc_write;
  logic               flush;
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               id_valid;
  logic               id_ready;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;
`ifdef FETCH_MISALIGN_CHK_EN
  logic               id_fault;
`endif

  modport master (
    input  pc, flush, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    output pc_write, imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
`ifdef FETCH_MISALIGN_CHK_EN
    , output id_fault
`endif
  );

  modport slave (
    output pc, flush, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
    input  pc_write, imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
`ifdef FETCH_MISALIGN_CHK_EN
    , input id_fault
`endif
  );
endinterface

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// IF-stage fetch controller. Issues one instruction-memory request at a time
// from the architectural PC, enables the PC register only when a request is
// accepted or a redirect happens, and presents fetched words to IF/ID through
// a valid/ready handshake. A one-entry hold buffer absorbs a response that
// arrives while IF/ID is stalled; a flush kills IF/ID, the hold buffer and any
// in-flight response.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   if_fetch_unit_if.master (PC, flush, imem request/response, IF/ID)
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   When defined, a PC with non-zero low bits is not fetched; instead IF/ID
//   receives a NOP tagged with id_fault, and fetch parks until a flush.
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [ADDR_W-1:0]  req_pc_r, req_pc_nxt_s;
  logic [ADDR_W-1:0]  hold_pc_r, hold_pc_nxt_s;
  logic [INSTR_W-1:0] hold_instr_r, hold_instr_nxt_s;
  logic               id_valid_r, id_valid_nxt_s;
  logic [ADDR_W-1:0]  id_pc_r, id_pc_nxt_s;
  logic [INSTR_W-1:0] id_instr_r, id_instr_nxt_s;
  logic               req_valid_s;
  logic               pc_write_s;
  logic               slot_free_s;
  logic               misalign_s;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013);
  logic fault_r, fault_nxt_s;
  // Set once the fault NOP has been handed to IF/ID so it is not repeated.
  logic lock_r, lock_nxt_s;
  assign misalign_s = (bus.pc[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // IF/ID can take a new word when empty or being drained this cycle.
  assign slot_free_s = !id_valid_r || bus.id_ready;

  // Next-state, request and IF/ID load decisions.
  always_comb begin
    state_nxt_s      = state_r;
    req_pc_nxt_s     = req_pc_r;
    hold_pc_nxt_s    = hold_pc_r;
    hold_instr_nxt_s = hold_instr_r;
    id_valid_nxt_s   = id_valid_r && !bus.id_ready;
    id_pc_nxt_s      = id_pc_r;
    id_instr_nxt_s   = id_instr_r;
    req_valid_s      = 1'b0;
    pc_write_s       = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    fault_nxt_s      = fault_r;
    lock_nxt_s       = lock_r;
`endif

    if (bus.flush) begin
      // Redirect: PC loads the target; a pending response must be swallowed.
      pc_write_s     = 1'b1;
      id_valid_nxt_s = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      lock_nxt_s     = 1'b0;
`endif
      if (((state_r == ST_WAIT) || (state_r == ST_DRAIN)) && !bus.imem_resp_valid) begin
        state_nxt_s = ST_DRAIN;
      end else begin
        state_nxt_s = ST_REQ;
      end
    end else begin
      case (state_r)
        ST_REQ: begin
          if (misalign_s) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (!lock_r && slot_free_s) begin
              id_valid_nxt_s = 1'b1;
              id_pc_nxt_s    = bus.pc;
              id_instr_nxt_s = NOP_INSTR;
              fault_nxt_s    = 1'b1;
              lock_nxt_s     = 1'b1;
            end else begin
              lock_nxt_s     = lock_r;
            end
`endif
          end else begin
            req_valid_s = 1'b1;
            if (bus.imem_req_ready) begin
              pc_write_s   = 1'b1;
              req_pc_nxt_s = bus.pc;
              state_nxt_s  = ST_WAIT;
            end else begin
              state_nxt_s  = ST_REQ;
            end
          end
        end
        ST_WAIT: begin
          if (bus.imem_resp_valid) begin
            if (slot_free_s) begin
              id_valid_nxt_s = 1'b1;
              id_pc_nxt_s    = req_pc_r;
              id_instr_nxt_s = bus.imem_resp_data;
`ifdef FETCH_MISALIGN_CHK_EN
              fault_nxt_s    = 1'b0;
`endif
              state_nxt_s    = ST_REQ;
            end else begin
              hold_pc_nxt_s    = req_pc_r;
              hold_instr_nxt_s = bus.imem_resp_data;
              state_nxt_s      = ST_HOLD;
            end
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          // Only entered with IF/ID occupied, so id_ready is the free condition.
          if (bus.id_ready) begin
            id_valid_nxt_s = 1'b1;
            id_pc_nxt_s    = hold_pc_r;
            id_instr_nxt_s = hold_instr_r;
`ifdef FETCH_MISALIGN_CHK_EN
            fault_nxt_s    = 1'b0;
`endif
            state_nxt_s    = ST_REQ;
          end else begin
            state_nxt_s    = ST_HOLD;
          end
        end
        ST_DRAIN: begin
          if (bus.imem_resp_valid) begin
            state_nxt_s = ST_REQ;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        default: begin
          state_nxt_s = ST_REQ;
        end
      endcase
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // The fault tag never outlives the entry it belongs to.
    fault_nxt_s = fault_nxt_s && id_valid_nxt_s;
`endif
  end

  // State, request bookkeeping, hold buffer and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_REQ;
      req_pc_r     <= '0;
      hold_pc_r    <= '0;
      hold_instr_r <= '0;
      id_valid_r   <= 1'b0;
      id_pc_r      <= '0;
      id_instr_r   <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_r      <= 1'b0;
      lock_r       <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt_s;
      req_pc_r     <= req_pc_nxt_s;
      hold_pc_r    <= hold_pc_nxt_s;
      hold_instr_r <= hold_instr_nxt_s;
      id_valid_r   <= id_valid_nxt_s;
      id_pc_r      <= id_pc_nxt_s;
      id_instr_r   <= id_instr_nxt_s;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_r      <= fault_nxt_s;
      lock_r       <= lock_nxt_s;
`endif
    end
  end

  // Request and PC enable are combinational so acceptance and PC advance
  // happen in the same cycle; both are forced low during reset.
  assign bus.imem_req_valid = req_valid_s && !rst;
  assign bus.imem_req_addr  = bus.pc;
  assign bus.pc_write       = pc_write_s && !rst;
  assign bus.id_valid       = id_valid_r;
  assign bus.id_pc          = id_pc_r;
  assign bus.id_instr       = id_instr_r;
`ifdef FETCH_MISALIGN_CHK_EN
  assign bus.id_fault       = fault_r;
`endif

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch control for each core's IF stage. It reads the architectural PC, issues one instruction-memory request at a time, and returns the fetched word with its PC to IF/ID through a valid/ready handshake. It generates pc_write, the enable for the PC register, so the PC advances only when a fetch is accepted or a redirect occurs. It absorbs decode stalls and branch or exception flushes.

Parameters:
ADDR_W, 32, width of PC and instruction-memory address
INSTR_W, 32, instruction word width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
pc  in  ADDR_W  current PC from the PC register
pc_write  out  1  PC register update enable
flush  in  1  redirect/kill from EX or branch unit; PC_Next carries the target this cycle
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address
imem_resp_valid  in  1  single-cycle response pulse, in request order
imem_resp_data  in  INSTR_W  fetched instruction
id_valid  out  1  IF/ID holds a valid instruction
id_ready  in  1  decode consumes this cycle; 0 = stall from hazard unit
id_pc  out  ADDR_W  PC of the instruction in IF/ID
id_instr  out  INSTR_W  instruction in IF/ID

Behaviour:
- Reset (rst=1 at an edge):
  - state=REQ; id_valid=0; id_pc=0; id_instr=0; hold buffer empty.
  - pc_write=0 and imem_req_valid=0 while rst=1.
- At most one outstanding memory request. States: REQ, WAIT, HOLD, DRAIN.
- REQ:
  - Drives imem_req_valid=1 and imem_req_addr=pc (combinational).
  - On req_valid&req_ready: latch req_pc=pc, pc_write=1 in the same cycle, go to WAIT.
- WAIT:
  - imem_req_valid=0; waits for imem_resp_valid.
  - On a response, if the output slot is free (!id_valid | id_ready): load id_instr=resp_data, id_pc=req_pc, id_valid=1 next edge; go to REQ.
  - Otherwise capture the word and PC in the hold buffer; go to HOLD.
- HOLD:
  - No requests. When id_ready=1, move the buffer into IF/ID (id_valid stays 1) and go to REQ.
- Output handshake:
  - id_valid&id_ready with no new load clears id_valid next edge.
  - While id_ready=0, id_pc and id_instr are stable.
- Flush (highest priority, any state):
  - imem_req_valid=0 that cycle; pc_write=1, so the PC loads the redirect target.
  - id_valid clears and the hold buffer empties at the next edge.
  - If a request is in flight (in WAIT, without a same-cycle response), go to DRAIN. Otherwise go to REQ.
  - A flush in the same cycle as a response discards that response.
- DRAIN: discard the next imem_resp_valid, then go to REQ. A further flush while in DRAIN stays in DRAIN.
- pc_write=0 in all other cases, i.e. the PC holds during memory wait, a stall, or HOLD.
- Latency: request accepted at cycle N, response at N+k (k≥1), id_valid at N+k+1.
  - Peak throughput is one instruction per 2 cycles with zero-wait memory.
- No arithmetic is performed in this block; PC+4 and the redirect mux live outside it.
- Reset mid-transaction: an in-flight response after reset is ignored, because the state is REQ and no request is recorded. The memory is reset by the same rst.

Optional Feature:
FETCH_MISALIGN_CHK_EN
- Defined:
  - Adds output id_fault (1 bit, reset 0).
  - In REQ, if pc[1:0]!=0, no memory request is issued.
  - pc_write stays 0 and IF/ID loads id_pc=pc, id_instr=32'h00000013 (NOP), id_valid=1, id_fault=1 when the slot is free.
  - The block then stays in REQ without re-fetching until flush.
  - id_fault follows id_valid/flush clear rules.
- Undefined:
  - No port; low address bits are passed through unchecked.

Test Plan:
1. Reset then zero-wait memory, pc stepping 0,4,8 → pc_write pulses at the cycles of request acceptance; id_pc=0,4,8 with matching instructions; id_valid first high 2 cycles after the first request.
2. imem_req_ready low 3 cycles with pc=0x100 → imem_req_addr stays 0x100; pc_write=0 until accept; exactly one id_valid beat for 0x100.
3. Response arrives while id_valid=1 and id_ready=0 for 4 cycles → IF/ID holds the prior instruction; the new word is in HOLD; no request issued; after id_ready=1 the next beat is the held word, then the next request.
4. Flush in WAIT (response 2 cycles later) with target 0x200 → pc_write=1 on flush; id_valid=0; the late response is dropped; next imem_req_addr=0x200 and next id_pc=0x200.
5. Flush in the same cycle as imem_resp_valid → response discarded, no DRAIN; next request at the redirect PC.
6. FETCH_MISALIGN_CHK_EN with pc=0x102 → no imem_req_valid; id_valid=1, id_fault=1, id_instr=0x00000013, id_pc=0x102; held until flush to 0x300 clears it.
